// File: rtl/jtopll_wr_if_if.sv
// Host-side write bus of the OPLL register interface: chip select, write
// strobe, address/data port select, write data and the busy flag back.
interface jtopll_wr_if_if;
    logic       cs_n;
    logic       wr_n;
    logic       addr;
    logic [7:0] din;
    logic       busy;

    modport master (output cs_n, wr_n, addr, din, input busy);
    modport slave  (input cs_n, wr_n, addr, din, output busy);
endinterface

// File: rtl/jtopll_wr_if.sv
// OPLL CPU write interface: latches address/data writes, holds each one until
// the core's cen grid samples it, and decodes it into channel update strobes.
module jtopll_wr_if (
    input  logic               clk,
    input  logic               rst,
    input  logic               cen,
    jtopll_wr_if_if.slave      host,
    output logic [3:0]         up_ch,
    output logic               up_fnumlo,
    output logic               up_fnumhi,
    output logic               up_inst,
    output logic               up_user,
    output logic [2:0]         up_ureg,
    output logic [7:0]         dout,
    output logic               rhy_en,
    output logic [4:0]         rhy_kon
);
    typedef enum logic [1:0] {IDLE, PEND, SHOW} state_t;

    state_t     state;
    logic [7:0] sel, aq, dq;
    logic       wr, wr_l, wr_ev;
    logic       is_user, is_rhy, is_chan;

    assign wr    = ~host.cs_n & ~host.wr_n;
    assign wr_ev = wr & ~wr_l;

    // Channel banks 0x1x/0x2x/0x3x only cover channels 0-8
    assign is_user = (aq[7:3] == 5'd0);
    assign is_rhy  = (aq == 8'h0E);
    assign is_chan = (aq[7:6] == 2'd0) && (aq[5:4] != 2'd0) && (aq[3:0] <= 4'd8);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            wr_l      <= 1'b0;
            sel       <= 8'd0;
            aq        <= 8'd0;
            dq        <= 8'd0;
            host.busy <= 1'b0;
            up_ch     <= 4'd0;
            up_fnumlo <= 1'b0;
            up_fnumhi <= 1'b0;
            up_inst   <= 1'b0;
            up_user   <= 1'b0;
            up_ureg   <= 3'd0;
            dout      <= 8'd0;
            rhy_en    <= 1'b0;
            rhy_kon   <= 5'd0;
        end else begin
            wr_l <= wr;
            if (wr_ev && !host.addr)
                sel <= host.din;
            case (state)
                IDLE: begin
                    if (wr_ev && host.addr) begin
                        aq        <= sel;
                        dq        <= host.din;
                        host.busy <= 1'b1;
                        state     <= PEND;
                    end
                end
                PEND: begin
                    if (cen) begin
                        dout  <= dq;
                        state <= SHOW;
                        if (is_user) begin
                            up_user <= 1'b1;
                            up_ureg <= aq[2:0];
                        end else if (is_rhy) begin
                            rhy_en  <= dq[5];
                            rhy_kon <= dq[4:0];
                        end else if (is_chan) begin
                            up_ch     <= aq[3:0];
                            up_fnumlo <= (aq[5:4] == 2'd1);
                            up_fnumhi <= (aq[5:4] == 2'd2);
                            up_inst   <= (aq[5:4] == 2'd3);
                        end
                    end
                end
                SHOW: begin
                    // Data writes on this edge still see busy=1 and are dropped
                    if (cen) begin
                        up_fnumlo <= 1'b0;
                        up_fnumhi <= 1'b0;
                        up_inst   <= 1'b0;
                        up_user   <= 1'b0;
                        host.busy <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/jtopll_wr_if.md
# jtopll_wr_if

CPU-facing register write interface for the OPLL core. It captures address/data writes from the host bus and decodes them into the per-channel update strobes and rhythm control consumed by the channel register stage. It also holds each decoded write until the core's clock-enable grid can sample it, and reports `busy` to the host while a write is in flight.

## Interface
Parameters: none.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  system clock
- `rst`  in  1  synchronous active-high reset
- `cen`  in  1  core clock enable; the consumer samples outputs on `clk` edges where `cen`=1
- `cs_n`  in  1  chip select, active low
- `wr_n`  in  1  write strobe, active low
- `addr`  in  1  0 = address port, 1 = data port
- `din`  in  8  host write data
- `up_ch`  out  4  channel index of current update (0-8)
- `up_fnumlo`  out  1  update fnum[7:0] (regs 0x10-0x18)
- `up_fnumhi`  out  1  update sus/keyon/block/fnum[8] (regs 0x20-0x28)
- `up_inst`  out  1  update inst/vol (regs 0x30-0x38)
- `up_user`  out  1  update user-instrument register (regs 0x00-0x07)
- `up_ureg`  out  3  user-instrument register index
- `dout`  out  8  data of current update
- `rhy_en`  out  1  rhythm mode enable (reg 0x0E bit 5)
- `rhy_kon`  out  5  rhythm key-on: [4]=BD, [3]=SD, [2]=TOM, [1]=TC, [0]=HH (reg 0x0E bits 4:0)
- `busy`  out  1  high while a data write is pending or being presented

## Operation
- Write event: `wr` = !cs_n & !wr_n, registered as `wr_l`. An event occurs on a `clk` edge where `wr`=1 and `wr_l`=0. This is edge-detected, so a held-low strobe produces exactly one event.
- Address event (`addr`=0): `sel` <= `din`. This is accepted regardless of `busy`.
- Data event (`addr`=1) with `busy`=0: `aq` <= `sel`, `dq` <= `din`, and the state goes IDLE -> PEND. `busy` goes high on the same edge.
- Data event with `busy`=1: the event is dropped. There is no state change, and `aq`/`dq` are unchanged.
- States:
  - IDLE: no strobes, `busy`=0.
  - PEND: on the first edge with `cen`=1, load the decoded strobes, `up_ch`, `up_ureg` and `dout`. Go to SHOW.
  - SHOW: strobes are held. On the next edge with `cen`=1, clear all strobes and go to IDLE, which drops `busy`.
- Decode from `aq` when loading in PEND:
  - 0x00-0x07: `up_user`=1, `up_ureg`=`aq[2:0]`.
  - 0x0E: `rhy_en`<=`dq[5]`, `rhy_kon`<=`dq[4:0]`. These are persistent registers, not strobes.
  - 0x10-0x18: `up_fnumlo`=1, `up_ch`=`aq[3:0]`.
  - 0x20-0x28: `up_fnumhi`=1, `up_ch`=`aq[3:0]`.
  - 0x30-0x38: `up_inst`=1, `up_ch`=`aq[3:0]`.
  - Any other address (e.g. 0x19-0x1F, 0x08-0x0D, 0x0F, 0x39+): no strobe and no register change. The PEND -> SHOW -> IDLE sequence still runs, so `busy` timing is uniform.
- At most one of `up_*` is high at any time.
- `up_ch`, `up_ureg` and `dout` hold their last loaded values after the strobes clear.

## Timing
- Reset: every output is 0 (`up_*`, `up_ch`, `up_ureg`, `dout`, `rhy_en`, `rhy_kon`, `busy`). Internally `sel`=0, `aq`=0, `dq`=0, `wr_l`=0, state IDLE.
- Reset mid-operation: a pending or showing write is discarded and no strobe is emitted after reset.
- Latency: data event edge -> strobes high after the first following `cen` edge. The consumer registers the update at the second `cen` edge after the event.
- Strobes are high for exactly one `cen` period: from one `cen` edge to the next.
- `busy` is high from the data event edge through the edge that clears the strobes.
- With `cen` held at 1, `busy` lasts 2 clk cycles after the event edge.
- With `cen` stuck at 0, PEND or SHOW is held indefinitely and `busy` stays high.
- A data event on the same edge that clears SHOW is dropped, because `busy` is still 1 at that edge.
- An address event during PEND or SHOW does not alter `aq`.
- Rhythm registers (`rhy_en`, `rhy_kon`) update on the PEND-load `cen` edge and then persist until the next 0x0E write or reset.

## Test plan
- `cen` is 1 every 4th clk. Write addr 0x13, then data 0xA5 -> `up_fnumlo`=1, `up_ch`=3, `dout`=0xA5 for exactly one `cen` period. `busy` is high from the event until the strobes clear.
- Write 0x25 then 0x1C -> `up_fnumhi`=1, `up_ch`=5, `dout`=0x1C. Write 0x34 then 0x7F -> `up_inst`=1, `up_ch`=4.
- Write 0x0E then 0x3F -> after the first `cen` edge, `rhy_en`=1 and `rhy_kon`=5'h1F, with no `up_*` strobe. A later write of 0x0E then 0x00 clears both.
- Write 0x19 then 0xFF -> no strobe and no register change, while `busy` still pulses for the normal duration.
- Data write 0x11/0x01 followed immediately by data 0x02 while `busy` is high -> only `dout`=0x01 is presented. A held-low `wr_n` produces a single event.
- Hold `cen`=0 after write 0x07 then 0x55 -> `busy` stays 1 and `up_user` stays 0. Assert `rst` -> all outputs are 0. Release reset and pulse `cen` -> no strobe appears.
